alu_rf_sequencer: RTL
=====================

// Module: alu_rf_sequencer
// PURPOSE
//  Multi-cycle initiator driving the 4-bit register file and 8-op ALU.
//  Accepts one 9-bit instruction, reads two source registers through the single RF read port,
//  runs the ALU, and writes the result back.
//  Sits between an instruction source (bench or fetch unit) and the register_file/alu pair.
//  Role: this block issues requests; the RF and ALU respond.
// PARAMETERS
//  WIDTH   4  data width of registers / ALU operands
//  RAW     2  register address width (4 registers)
//  OPW     3  ALU control width
//  CNTW    8  retired-instruction counter width
// PORTS
//  clk           in   1      clock; all state changes on rising edge
//  reset         in   1      asynchronous, active-high reset
//  instr_valid   in   1      instruction present on instr
//  instr         in   9      [8:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2; imm = [3:0]
//  instr_ready   out  1      block can accept an instruction this cycle
//  rf_rd_addr    out  RAW    RF read address
//  rf_rd_data    in   WIDTH  RF read data (combinational from rf_rd_addr)
//  rf_we         out  1      RF write enable (RF latches on falling clk edge)
//  rf_we_addr    out  RAW    RF write address
//  rf_we_data    out  WIDTH  RF write data
//  alu_control   out  OPW    ALU op select
//  alu_a, alu_b  out  WIDTH  ALU operands
//  alu_res       in   WIDTH  ALU result (combinational)
//  done          out  1      one-cycle pulse: instruction in write-back
//  retired       out  CNTW   count of completed instructions
// BEHAVIOUR
//  Ops: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 ADD, 5 SUB, 6 SLT (sent to ALU unchanged); 7 LOADI.
//  FSM: IDLE -> RDA -> RDB -> EXEC -> WB -> IDLE. LOADI: IDLE -> WB -> IDLE.
//  IDLE: instr_ready=1. On valid&ready at edge E0, latch instr; if LOADI, also res_q<=imm.
//  RDA:  rf_rd_addr=rs1; op_a<=rf_rd_data at edge.
//  RDB:  rf_rd_addr=rs2; op_b<=rf_rd_data at edge.
//  EXEC: alu_a=op_a, alu_b=op_b, alu_control=op; res_q<=alu_res at edge.
//  WB:   rf_we=1, rf_we_addr=rd, rf_we_data=res_q, done=1; retired+1 at exit edge.
//  Latency: ALU op done in cycle after E3, IDLE after E4; LOADI done in cycle after E0.
//  Throughput: no overlap. Next instruction is accepted only in IDLE.
//  instr_valid outside IDLE is ignored; the source holds it until ready.
//  Read-after-write is safe: the WB write lands on the falling edge inside WB, before the next RDA.
//  rf_we and done are decoded from the state register only (no input paths).
//  Outside their states: alu_*, rf_rd_addr, rf_we_addr, rf_we_data = 0.
//  Arithmetic: all modulo 2^WIDTH; retired wraps 2^CNTW-1 -> 0.
//  Reset (async, any state): state=IDLE, op_a/op_b/res_q/instr reg=0, retired=0.
//   rf_we=0, done=0 immediately; instr_ready=0 while reset is high, 1 after release.
//   Reset in WB before the falling edge: no write.
//   RF contents are not reset by this block.
// STRUCTURE
//  Shared package/header: op encodings (OP_AND..OP_LOADI), instr field offsets, FSM state codes.
//  No sub-module. One FSM plus datapath registers (op_a, op_b, res_q, instr reg, retired).
//  Optional alu_rf_top wrapper instantiates this block with register_file and alu for system tests.
// TESTING (bench uses real register_file + alu)
//  1 LOADI r1,5 (9'b111_01_0101): done 1 cycle after accept, rf_we_addr=1, rf_we_data=5, retired=1.
//  2 LOADI r2,3; ADD r3,r1,r2 (9'b100_11_01_10): EXEC alu_a=5, alu_b=3; WB data=8, done 4 cycles after accept.
//  3 SUB r0,r0,r1 with r0=0, r1=5 -> r0=4'hB. LOADI r1,9; ADD r1,r1,r1 -> 2 (wrap).
//  4 SLT r3,r1,r2 with r1=5, r2=3 -> 0; SLT r3,r2,r1 -> 1.
//  5 Back-to-back hazard: r1=5; ADD r1,r1,r1 twice -> 10 then 4.
//    instr_valid held high throughout -> instr_ready=0 in RDA..WB; second accept only in IDLE.
//  6 Reset pulse in EXEC: rf_we never asserted, target register unchanged, state IDLE, retired=0.
//    Next LOADI completes normally.

Source files
------------

// File: rtl/alu_rf_sequencer_pkg.sv
// Shared encodings for the ALU/register-file sequencer: opcodes, instruction
// field offsets and FSM state codes.
package alu_rf_sequencer_pkg;

    localparam int INSTR_W = 9;
    localparam int OP_LSB  = 6;
    localparam int RD_LSB  = 4;
    localparam int RS1_LSB = 2;
    localparam int RS2_LSB = 0;
    localparam int IMM_W   = 4;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_NAND  = 3'd1,
        OP_OR    = 3'd2,
        OP_NOR   = 3'd3,
        OP_ADD   = 3'd4,
        OP_SUB   = 3'd5,
        OP_SLT   = 3'd6,
        OP_LOADI = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDA  = 3'd1,
        S_RDB  = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_e;

endpackage

// File: rtl/alu_rf_sequencer_if.sv
// Instruction handshake plus the register-file and ALU request/response wires.
// master = the sequencer, slave = instruction source and RF/ALU side.
interface alu_rf_sequencer_if
    import alu_rf_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int RAW   = 2,
    parameter int OPW   = 3,
    parameter int CNTW  = 8
);
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_ready;
    logic [RAW-1:0]     rf_rd_addr;
    logic [WIDTH-1:0]   rf_rd_data;
    logic               rf_we;
    logic [RAW-1:0]     rf_we_addr;
    logic [WIDTH-1:0]   rf_we_data;
    logic [OPW-1:0]     alu_control;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [WIDTH-1:0]   alu_res;
    logic               done;
    logic [CNTW-1:0]    retired;

    modport master (
        input  instr_valid, instr, rf_rd_data, alu_res,
        output instr_ready, rf_rd_addr, rf_we, rf_we_addr, rf_we_data,
               alu_control, alu_a, alu_b, done, retired
    );

    modport slave (
        output instr_valid, instr, rf_rd_data, alu_res,
        input  instr_ready, rf_rd_addr, rf_we, rf_we_addr, rf_we_data,
               alu_control, alu_a, alu_b, done, retired
    );

endinterface

// File: rtl/alu_rf_sequencer.sv
// Multi-cycle initiator: fetches two operands through the single RF read port,
// runs the external ALU, and writes the result back. One instruction at a time.
module alu_rf_sequencer
    import alu_rf_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int RAW   = 2,
    parameter int OPW   = 3,
    parameter int CNTW  = 8
) (
    input logic                clk,
    input logic                reset,
    alu_rf_sequencer_if.master bus
);

    state_e             state;
    logic [INSTR_W-1:0] instr_q;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   res_q;
    logic [CNTW-1:0]    retired_q;

    logic [OPW-1:0]     op_f;
    logic [RAW-1:0]     rd_f;
    logic [RAW-1:0]     rs1_f;
    logic [RAW-1:0]     rs2_f;
    logic               new_is_loadi;

    assign op_f  = instr_q[OP_LSB +: OPW];
    assign rd_f  = instr_q[RD_LSB +: RAW];
    assign rs1_f = instr_q[RS1_LSB +: RAW];
    assign rs2_f = instr_q[RS2_LSB +: RAW];
    assign new_is_loadi = (bus.instr[OP_LSB +: OPW] == OPW'(OP_LOADI));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            instr_q   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            res_q     <= '0;
            retired_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q <= bus.instr;
                        // LOADI bypasses the ALU: the immediate is the result.
                        if (new_is_loadi) begin
                            res_q <= WIDTH'(bus.instr[IMM_W-1:0]);
                            state <= S_WB;
                        end else begin
                            state <= S_RDA;
                        end
                    end
                end
                S_RDA: begin
                    op_a  <= bus.rf_rd_data;
                    state <= S_RDB;
                end
                S_RDB: begin
                    op_b  <= bus.rf_rd_data;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    res_q <= bus.alu_res;
                    state <= S_WB;
                end
                S_WB: begin
                    retired_q <= retired_q + CNTW'(1);
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [RAW-1:0]   rd_addr_c;
    logic             we_c;
    logic [RAW-1:0]   we_addr_c;
    logic [WIDTH-1:0] we_data_c;
    logic [OPW-1:0]   alu_ctl_c;
    logic [WIDTH-1:0] alu_a_c;
    logic [WIDTH-1:0] alu_b_c;

    // Request-side outputs depend on state and datapath registers only; idle value is zero.
    always_comb begin
        rd_addr_c = '0;
        we_c      = 1'b0;
        we_addr_c = '0;
        we_data_c = '0;
        alu_ctl_c = '0;
        alu_a_c   = '0;
        alu_b_c   = '0;
        case (state)
            S_RDA:  rd_addr_c = rs1_f;
            S_RDB:  rd_addr_c = rs2_f;
            S_EXEC: begin
                alu_ctl_c = op_f;
                alu_a_c   = op_a;
                alu_b_c   = op_b;
            end
            S_WB: begin
                we_c      = 1'b1;
                we_addr_c = rd_f;
                we_data_c = res_q;
            end
            default: ;
        endcase
    end

    assign bus.instr_ready = (state == S_IDLE) && !reset;
    assign bus.rf_rd_addr  = rd_addr_c;
    assign bus.rf_we       = we_c;
    assign bus.rf_we_addr  = we_addr_c;
    assign bus.rf_we_data  = we_data_c;
    assign bus.alu_control = alu_ctl_c;
    assign bus.alu_a       = alu_a_c;
    assign bus.alu_b       = alu_b_c;
    assign bus.done        = we_c;
    assign bus.retired     = retired_q;

endmodule
